// File: rtl/ahb_slv_mem.sv
// AHB-Lite memory slave with configurable wait states and byte-lane strobing.
// Define AHB_SLV_ERR_EN to return a two-cycle ERROR response for illegal transfers.
module ahb_slv_mem #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned LsbW  = $clog2(Bytes);
  localparam int unsigned IdxW  = $clog2(MEM_DEPTH);
  localparam longint unsigned MemBytes = 64'(MEM_DEPTH) * 64'(Bytes);
  localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData
`ifdef AHB_SLV_ERR_EN
    ,
    StErr1,
    StErr2
`endif
  } state_e;

  state_e            state_q, state_d, acc_state;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [Bytes-1:0]  strb_q, strb_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic              accept, take;
  logic              oversize, misalign, out_of_range, illegal;
  logic [2:0]        size_eff;
  logic [LsbW-1:0]   size_mask, lane_off;
  logic [Bytes-1:0]  strb;

  logic unused_htrans0;
  assign unused_htrans0 = htrans[0];

  // Address-phase decode. Oversize is clipped and misalignment aligned down, so the
  // strobes are also correct for the non-error build.
  always_comb begin
    oversize     = hsize > 3'(LsbW);
    size_eff     = oversize ? 3'(LsbW) : hsize;
    size_mask    = LsbW'((32'd1 << size_eff) - 32'd1);
    misalign     = |(haddr[LsbW-1:0] & size_mask);
    lane_off     = haddr[LsbW-1:0] & ~size_mask;
    out_of_range = 64'(haddr) >= MemBytes;
    illegal      = oversize | misalign | out_of_range;
    for (int b = 0; b < Bytes; b++) begin
      strb[b] = ((LsbW'(b) & ~size_mask) == lane_off);
    end
  end

`ifndef AHB_SLV_ERR_EN
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    idx_d     = idx_q;
    strb_d    = strb_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    take      = 1'b0;
    accept    = hsel & htrans[1] & hready;

    acc_state = StIdle;
    if (accept) begin
`ifdef AHB_SLV_ERR_EN
      if (illegal) acc_state = StErr1;
      else
`endif
      if (WAIT_CYCLES > 0) acc_state = StWait;
      else acc_state = StData;
    end

    unique case (state_q)
      StIdle, StData: take = 1'b1;
      StWait: begin
        hreadyout = 1'b0;
        if (cnt_q == 4'd0) state_d = StData;
        else cnt_d = cnt_q - 4'd1;
      end
`ifdef AHB_SLV_ERR_EN
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = StErr2;
      end
      StErr2: begin
        hresp = 1'b1;
        take  = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase

    // States whose cycle ends with hreadyout=1 may open the next data phase.
    if (take) begin
      state_d = acc_state;
      if (accept) begin
        write_d = hwrite;
        idx_d   = haddr[LsbW +: IdxW];
        strb_d  = strb;
        cnt_d   = WaitLoad;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
    end
  end

  // Array is not reset; writes commit on the completing data-phase edge only.
  always_ff @(posedge hclk) begin
    if (state_q == StData && write_q) begin
      for (int b = 0; b < Bytes; b++) begin
        if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if (state_q == StData && !write_q) hrdata = mem_q[idx_q];
  end

endmodule
